// File: rtl/calc_pkg.sv
// Shared types and constants for the RPN calculator control path.
// Holds the enter-button debouncer state encoding and the calculator status encoding.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW   = 2'b00,
    CHECK_HIGH = 2'b01,
    HELD_HIGH  = 2'b10,
    CHECK_LOW  = 2'b11
  } debounceState_t;

  typedef enum logic [1:0] {
    CALC_WAIT_A  = 2'b00,
    CALC_WAIT_B  = 2'b01,
    CALC_WAIT_OP = 2'b10,
    CALC_SHOW    = 2'b11
  } calcState_t;

  localparam int DEFAULT_SYNC_STAGES   = 2;
  localparam int DEFAULT_STABLE_CYCLES = 500000;

  function automatic logic isBusyState(input debounceState_t s);
    return (s == CHECK_HIGH) || (s == CHECK_LOW);
  endfunction

  function automatic logic isLevelState(input debounceState_t s);
    return (s == HELD_HIGH) || (s == CHECK_LOW);
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchroniser for a single asynchronous switch input.
// STAGES must be at least 2; q is the output of the last stage.
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_r;

  // Shift the raw input through the chain; reset clears every stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain_r <= {STAGES{1'b0}};
    end else begin
      chain_r <= {chain_r[STAGES-2:0], d};
    end
  end

  assign q = chain_r[STAGES-1];

endmodule

// File: rtl/button_pulse_conditioner.sv
// Synchronises and debounces the enter push-button, producing a one-cycle press
// pulse for the calculator FSM plus a release pulse, clean level and busy flag.
module button_pulse_conditioner
  import calc_pkg::*;
#(
  parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic in_RawButton,
  output logic DataDebouncedOut,
  output logic out_ReleasePulse,
  output logic out_Level,
  output logic out_Busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic           syncQ_s;
  debounceState_t state_r, nextState_s, prevState_r;
  logic [CNT_W-1:0] cnt_r, nextCnt_s;

  sync_ff_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in_RawButton),
    .q     (syncQ_s)
  );

  // State and stability counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE_LOW;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= nextState_s;
      cnt_r   <= nextCnt_s;
    end
  end

  // Any disagreement during a CHECK state falls back to the old stable state.
  always_comb begin
    nextState_s = state_r;
    nextCnt_s   = cnt_r;
    case (state_r)
      IDLE_LOW: begin
        if (syncQ_s) begin
          nextState_s = CHECK_HIGH;
          nextCnt_s   = CNT_ZERO;
        end else begin
          nextState_s = IDLE_LOW;
          nextCnt_s   = CNT_ZERO;
        end
      end
      CHECK_HIGH: begin
        if (!syncQ_s) begin
          nextState_s = IDLE_LOW;
          nextCnt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          nextState_s = HELD_HIGH;
          nextCnt_s   = CNT_ZERO;
        end else begin
          nextCnt_s   = cnt_r + CNT_ONE;
        end
      end
      HELD_HIGH: begin
        if (!syncQ_s) begin
          nextState_s = CHECK_LOW;
          nextCnt_s   = CNT_ZERO;
        end else begin
          nextState_s = HELD_HIGH;
          nextCnt_s   = CNT_ZERO;
        end
      end
      CHECK_LOW: begin
        if (syncQ_s) begin
          nextState_s = HELD_HIGH;
          nextCnt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          nextState_s = IDLE_LOW;
          nextCnt_s   = CNT_ZERO;
        end else begin
          nextCnt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        nextState_s = IDLE_LOW;
        nextCnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Registered outputs; pulses fire the cycle after the accepting transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prevState_r      <= IDLE_LOW;
      DataDebouncedOut <= 1'b0;
      out_ReleasePulse <= 1'b0;
      out_Level        <= 1'b0;
      out_Busy         <= 1'b0;
    end else begin
      prevState_r      <= state_r;
      DataDebouncedOut <= (state_r == HELD_HIGH) && (prevState_r == CHECK_HIGH);
      out_ReleasePulse <= (state_r == IDLE_LOW) && (prevState_r == CHECK_LOW);
      out_Level        <= isLevelState(state_r);
      out_Busy         <= isBusyState(state_r);
    end
  end

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Directed bench for button_pulse_conditioner with STABLE_CYCLES=8, SYNC_STAGES=2.
module tb_button_pulse_conditioner;
  import calc_pkg::*;

  logic clk;
  logic reset;
  logic in_RawButton;
  logic DataDebouncedOut;
  logic out_ReleasePulse;
  logic out_Level;
  logic out_Busy;

  int assertCount = 0;
  int failCount   = 0;

  button_pulse_conditioner #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .in_RawButton     (in_RawButton),
    .DataDebouncedOut (DataDebouncedOut),
    .out_ReleasePulse (out_ReleasePulse),
    .out_Level        (out_Level),
    .out_Busy         (out_Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and land on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [3:0] allOuts();
    return {DataDebouncedOut, out_ReleasePulse, out_Level, out_Busy};
  endfunction

  int presses, releases, overlaps, lastPress, minGap, tCount;
  calcState_t calcSt;

  task automatic observe();
    tCount++;
    if (DataDebouncedOut && out_ReleasePulse) overlaps++;
    if (DataDebouncedOut) begin
      presses++;
      if (tCount - lastPress < minGap) minGap = tCount - lastPress;
      lastPress = tCount;
      calcSt = calcState_t'(calcSt + 2'd1);
    end
    if (out_ReleasePulse) releases++;
  endtask

  initial begin
    reset = 1'b0;
    in_RawButton = 1'b0;

    // Reset held with a toggling input
    for (int i = 0; i < 10; i++) begin
      in_RawButton = i[0];
      tick();
      checkVal($sformatf("in reset i=%0d", i), 32'(allOuts()), 32'd0);
    end
    in_RawButton = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      checkVal($sformatf("after reset i=%0d", i), 32'(allOuts()), 32'd0);
    end

    // Clean press: raw sampled high at edge 0
    in_RawButton = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      tick();
      checkVal($sformatf("press pulse k=%0d", k), 32'(DataDebouncedOut), 32'(k == 11));
      checkVal($sformatf("press level k=%0d", k), 32'(out_Level), 32'(k >= 11));
      checkVal($sformatf("press busy k=%0d", k), 32'(out_Busy), 32'(k >= 3 && k <= 10));
    end

    // Short low glitch while held must not release
    in_RawButton = 1'b0;
    repeat (5) tick();
    in_RawButton = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      checkVal($sformatf("glitch rel k=%0d", k), 32'(out_ReleasePulse), 32'd0);
      checkVal($sformatf("glitch level k=%0d", k), 32'(out_Level), 32'd1);
    end

    // Release
    in_RawButton = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      tick();
      checkVal($sformatf("rel pulse k=%0d", k), 32'(out_ReleasePulse), 32'(k == 11));
      checkVal($sformatf("rel level k=%0d", k), 32'(out_Level), 32'(k < 11));
      checkVal($sformatf("rel busy k=%0d", k), 32'(out_Busy), 32'(k >= 3 && k <= 10));
      checkVal($sformatf("rel no press k=%0d", k), 32'(DataDebouncedOut), 32'd0);
    end

    // Bounce with 3-cycle phases, then held high
    for (int i = 0; i < 42; i++) begin
      in_RawButton = ((i / 3) % 2 == 0);
      tick();
      checkVal($sformatf("bounce pulse i=%0d", i), 32'(DataDebouncedOut), 32'd0);
    end
    in_RawButton = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      tick();
      checkVal($sformatf("bounce final k=%0d", k), 32'(DataDebouncedOut), 32'(k == 11));
    end

    // Back to idle, then reset during qualification
    in_RawButton = 1'b0;
    repeat (30) tick();
    in_RawButton = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      tick();
      checkVal($sformatf("midchk busy k=%0d", k), 32'(out_Busy), 32'(k >= 3));
    end
    reset = 1'b0;
    #1;
    checkVal("midchk async clear", 32'(allOuts()), 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      checkVal($sformatf("midchk held k=%0d", k), 32'(allOuts()), 32'd0);
    end
    reset = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      tick();
      checkVal($sformatf("post reset pulse k=%0d", k), 32'(DataDebouncedOut), 32'(k == 11));
      checkVal($sformatf("post reset busy k=%0d", k), 32'(out_Busy), 32'(k >= 3 && k <= 10));
    end

    // Long holds driving the calculator status model
    in_RawButton = 1'b0;
    repeat (30) tick();
    presses = 0; releases = 0; overlaps = 0;
    lastPress = -100000; minGap = 100000; tCount = 0;
    calcSt = CALC_WAIT_A;
    for (int rep = 0; rep < 3; rep++) begin
      in_RawButton = 1'b1;
      for (int i = 0; i < 1000; i++) begin tick(); observe(); end
      in_RawButton = 1'b0;
      for (int i = 0; i < 100; i++) begin tick(); observe(); end
    end
    checkVal("hold presses", 32'(presses), 32'd3);
    checkVal("hold releases", 32'(releases), 32'd3);
    checkVal("hold overlap", 32'(overlaps), 32'd0);
    checkVal("hold min gap", 32'(minGap >= 18), 32'd1);
    checkVal("calc status", 32'(calcSt), 32'(CALC_SHOW));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
